// File: rtl/four_bit_counter.sv
// Two-nibble 8-bit up-counter with synchronous reset to INIT and count enable.
// Define FOUR_BIT_COUNTER_BCD_EN for two-digit BCD (mod 100); otherwise plain binary (mod 256).
module four_bit_counter #(
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] out
);

`ifdef FOUR_BIT_COUNTER_BCD_EN
    localparam logic [3:0] TERM = 4'd9;
`else
    localparam logic [3:0] TERM = 4'hF;
`endif

    logic [3:0] lo_q, lo_d;
    logic [3:0] hi_q, hi_d;
    logic       lo_carry;

    // ">=" folds an out-of-range BCD nibble (>9) onto the wrap path so it never counts through 10-15
    always_comb begin
        lo_carry = enable && (lo_q >= TERM);
        lo_d     = lo_q;
        hi_d     = hi_q;
        if (enable) begin
            lo_d = lo_carry ? '0 : lo_q + 4'd1;
        end
        if (lo_carry) begin
            hi_d = (hi_q >= TERM) ? '0 : hi_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q <= INIT[3:0];
            hi_q <= INIT[7:4];
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign out = {hi_q, lo_q};

endmodule

// File: tb/tb_four_bit_counter.sv
// Self-checking bench for four_bit_counter: integer-count reference model plus directed literal checks and random stimulus.
module tb_four_bit_counter;

`ifdef FOUR_BIT_COUNTER_BCD_EN
    localparam int MOD = 100;
    localparam bit BCD = 1'b1;
`else
    localparam int MOD = 256;
    localparam bit BCD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] out0;
    logic [7:0] out1;

    int checks = 0;
    int failures = 0;

    // Model state: plain counts in 0..MOD-1, independent of nibble structure.
    int  m0;
    int  m1;
    bit  model_valid = 1'b0;

    always #5 clk = ~clk;

    four_bit_counter dut0 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .out    (out0)
    );

    four_bit_counter #(.INIT(8'h42)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .out    (out1)
    );

    function automatic logic [7:0] enc(input int v);
        int d;
        if (BCD) d = ((v / 10) * 16) + (v % 10);
        else     d = v;
        return d[7:0];
    endfunction

    function automatic int init_count(input int raw);
        if (BCD) return ((raw / 16) * 10) + (raw % 16);
        else     return raw;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Apply inputs, advance one edge, update model, compare both DUTs against it.
    task automatic step(input logic r, input logic e);
        reset  = r;
        enable = e;
        @(posedge clk);
        if (r) begin
            m0 = init_count(8'h00);
            m1 = init_count(8'h42);
            model_valid = 1'b1;
        end else if (e) begin
            m0 = (m0 + 1) % MOD;
            m1 = (m1 + 1) % MOD;
        end
        #1;
        if (model_valid) begin
            check("model_dut0", out0, enc(m0));
            check("model_dut1", out1, enc(m1));
        end
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b0, e);
    endtask

    initial begin
        #1;
        // Reset
        step(1'b1, 1'b1);
        check("reset_val", out0, 8'h00);
        check("init_42", out1, 8'h42);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("reset_hold", out0, 8'h00);

        // Count and hold
        run(3, 1'b1);
        check("count3", out0, 8'h03);
        run(5, 1'b0);
        check("hold", out0, 8'h03);

        // Nibble carry
        step(1'b1, 1'b0);
        if (BCD) begin
            run(9, 1'b1);
            check("bcd_09", out0, 8'h09);
            run(1, 1'b1);
            check("bcd_carry_10", out0, 8'h10);
        end else begin
            run(15, 1'b1);
            check("bin_0F", out0, 8'h0F);
            run(1, 1'b1);
            check("bin_carry_10", out0, 8'h10);
        end

        // Full wrap
        step(1'b1, 1'b0);
        if (BCD) begin
            run(99, 1'b1);
            check("bcd_99", out0, 8'h99);
        end else begin
            run(255, 1'b1);
            check("bin_FF", out0, 8'hFF);
        end
        run(1, 1'b1);
        check("wrap_00", out0, 8'h00);

        // Reset mid-count
        step(1'b1, 1'b0);
        if (BCD) run(27, 1'b1);
        else     run(39, 1'b1);
        check("reach_27", out0, 8'h27);
        step(1'b1, 1'b1);
        check("midreset_00", out0, 8'h00);
        check("midreset_42", out1, 8'h42);
        run(1, 1'b1);
        check("after_reset_01", out0, 8'h01);
        check("init_plus1_43", out1, 8'h43);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
